// File: rtl/alu_muldiv.sv
// Sequential RV32I/M execute unit: single-cycle base ALU ops, iterative MUL/DIV/REM.
// One operation in flight; valid/ready handshakes on both sides.
module alu_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [9:0]      in_cid,
    input  logic [XLEN-1:0] in_arg1,
    input  logic [XLEN-1:0] in_arg2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      f3_q, f3_nxt;
    logic [XLEN-1:0] hi_q, hi_nxt, lo_q, lo_nxt, dvs_q, dvs_nxt;
    logic            neg_q, neg_nxt, bz_q, bz_nxt;
    logic            out_valid_nxt;
    logic [XLEN-1:0] out_data_nxt;

    logic [2:0]        f3_in;
    logic [6:0]        f7_in;
    logic [SHW-1:0]    shamt;
    logic              accept, sa_en, sb_en, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b, base_res;
    logic [XLEN:0]     sum, shifted, trial;
    logic [XLEN-1:0]   step_hi, step_lo, fin_res;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign f3_in    = in_cid[9:7];
    assign f7_in    = in_cid[6:0];
    assign shamt    = in_arg2[SHW-1:0];

    // Base ALU result; unknown encodings fall through to all ones
    always_comb begin
        base_res = '1;
        case (f3_in)
            3'b000: if (f7_in == F7_BASE) base_res = in_arg1 + in_arg2;
                    else if (f7_in == F7_ALT) base_res = in_arg1 - in_arg2;
            3'b001: if (f7_in == F7_BASE) base_res = in_arg1 << shamt;
            3'b010: if (f7_in == F7_BASE)
                        base_res = {{(XLEN-1){1'b0}}, $signed(in_arg1) < $signed(in_arg2)};
            3'b011: if (f7_in == F7_BASE) base_res = {{(XLEN-1){1'b0}}, in_arg1 < in_arg2};
            3'b100: if (f7_in == F7_BASE) base_res = in_arg1 ^ in_arg2;
            3'b101: if (f7_in == F7_BASE) base_res = in_arg1 >> shamt;
                    else if (f7_in == F7_ALT) base_res = XLEN'($signed(in_arg1) >>> shamt);
            3'b110: if (f7_in == F7_BASE) base_res = in_arg1 | in_arg2;
            3'b111: if (f7_in == F7_BASE) base_res = in_arg1 & in_arg2;
        endcase
    end

    // Operand magnitudes; MUL low half is sign-agnostic so it runs unsigned
    always_comb begin
        sa_en = (f3_in == 3'b001) || (f3_in == 3'b010) || (f3_in == 3'b100) || (f3_in == 3'b110);
        sb_en = (f3_in == 3'b001) || (f3_in == 3'b100) || (f3_in == 3'b110);
        a_neg = sa_en && in_arg1[XLEN-1];
        b_neg = sb_en && in_arg2[XLEN-1];
        mag_a = a_neg ? -in_arg1 : in_arg1;
        mag_b = b_neg ? -in_arg2 : in_arg2;
    end

    // One iteration: shift-add multiply step or restoring divide step
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (f3_q[2]) begin
            step_hi = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], ~trial[XLEN]};
        end else begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], lo_q[XLEN-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        case (f3_q)
            3'b000:         fin_res = prod_fix[XLEN-1:0];
            3'b100, 3'b101: fin_res = bz_q ? '1 : (neg_q ? -step_lo : step_lo);
            3'b110, 3'b111: fin_res = neg_q ? -step_hi : step_hi;
            default:        fin_res = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // Next-state and registered outputs
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        f3_nxt        = f3_q;
        hi_nxt        = hi_q;
        lo_nxt        = lo_q;
        dvs_nxt       = dvs_q;
        neg_nxt       = neg_q;
        bz_nxt        = bz_q;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        case (state)
            IDLE: if (accept) begin
                if (f7_in == F7_M) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(XLEN);
                    f3_nxt    = f3_in;
                    hi_nxt    = '0;
                    lo_nxt    = mag_a;
                    dvs_nxt   = mag_b;
                    neg_nxt   = (f3_in[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
                    bz_nxt    = (in_arg2 == '0);
                end else begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = base_res;
                end
            end
            BUSY: begin
                hi_nxt  = step_hi;
                lo_nxt  = step_lo;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = fin_res;
                end
            end
            DONE: if (out_ready) begin
                state_nxt     = IDLE;
                out_valid_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            bz_q      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            f3_q      <= f3_nxt;
            hi_q      <= hi_nxt;
            lo_q      <= lo_nxt;
            dvs_q     <= dvs_nxt;
            neg_q     <= neg_nxt;
            bz_q      <= bz_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: base ops, M ops, stall hold and mid-op reset.
module tb_alu_muldiv;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, in_ready, out_valid;
    logic [9:0]  in_cid;
    logic [31:0] in_arg1, in_arg2, out_data;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_cid(in_cid), .in_arg1(in_arg1), .in_arg2(in_arg2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Offer one op, return result and edges from accept to out_valid; consumes if out_ready
    task automatic do_op(input logic [9:0] cid, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output int lat);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_wait in_ready=%0b required=1", in_ready);
        end
        in_cid = cid; in_arg1 = a; in_arg2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_arg1 = 32'hDEADBEEF; in_arg2 = 32'h12345678; in_cid = 10'h3FF;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        data = out_data;
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_cid = '0; in_arg1 = '0; in_arg2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_state in_ready=%0b out_valid=%0b out_data=%h required 0/0/0",
                     in_ready, out_valid, out_data);
        end
        @(negedge clk) rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic test_base_ops();
        logic [9:0]  cid [10] = '{10'h000, 10'h020, 10'h2A0, 10'h100, 10'h180,
                                 10'h080, 10'h280, 10'h002, 10'h220, 10'h200};
        logic [31:0] a   [10] = '{32'h7FFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h1, 32'h80000000, 32'h5, 32'h5, 32'hF0F0F0F0};
        logic [31:0] b   [10] = '{32'h1, 32'h1, 32'h21, 32'h1, 32'h1,
                                 32'h21, 32'h4, 32'h3, 32'h3, 32'hFF00FF00};
        logic [31:0] exp [10] = '{32'h80000000, 32'hFFFFFFFF, 32'hC0000000, 32'h1, 32'h0,
                                 32'h2, 32'h08000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0FF00FF0};
        logic [31:0] d;
        int          l;
        for (int i = 0; i < 10; i++) begin
            do_op(cid[i], a[i], b[i], d, l);
            checks++;
            if (d !== exp[i] || l !== 1) begin
                failures++;
                $display("FAIL base_op[%0d] cid=%h data=%h lat=%0d required data=%h lat=1",
                         i, cid[i], d, l, exp[i]);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [9:0]  cid [11] = '{10'h001, 10'h081, 10'h181, 10'h101, 10'h201, 10'h301,
                                 10'h281, 10'h381, 10'h201, 10'h301, 10'h201};
        logic [31:0] a   [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7, 32'h7,
                                 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] b   [11] = '{32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h2, 32'h2, 32'h0, 32'h0,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic [31:0] exp [11] = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7,
                                 32'h80000000, 32'h0, 32'hFFFFFFFF};
        logic [31:0] d;
        int          l;
        for (int i = 0; i < 11; i++) begin
            do_op(cid[i], a[i], b[i], d, l);
            checks++;
            if (d !== exp[i] || l !== 33) begin
                failures++;
                $display("FAIL m_op[%0d] cid=%h data=%h lat=%0d required data=%h lat=33",
                         i, cid[i], d, l, exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        int          l;
        out_ready = 1'b0;
        do_op(10'h000, 32'h1, 32'h2, d, l);
        checks++;
        if (d !== 32'h3 || l !== 1) begin
            failures++;
            $display("FAIL stall_result data=%h lat=%0d required data=00000003 lat=1", d, l);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid; in_cid = 10'h000; in_arg1 = 32'(i); in_arg2 = 32'd100;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h3 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d] out_valid=%0b out_data=%h in_ready=%0b required 1/00000003/0",
                         i, out_valid, out_data, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_stray out_valid=%0b required=0", out_valid);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        int          l;
        logic        saw = 1'b0;
        @(negedge clk);
        in_cid = 10'h201; in_arg1 = 32'hFFFFFFF9; in_arg2 = 32'h2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_reset out_valid=%0b in_ready=%0b required 0/0", out_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_no_result saw_valid=%0b in_ready=%0b required 0/1", saw, in_ready);
        end
        do_op(10'h000, 32'h2, 32'h3, d, l);
        checks++;
        if (d !== 32'h5 || l !== 1) begin
            failures++;
            $display("FAIL abort_next_add data=%h lat=%0d required data=00000005 lat=1", d, l);
        end
    endtask

    initial begin
        test_reset();
        test_base_ops();
        test_muldiv();
        test_stall();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
